// File: rtl/serial_mod5_receiver_if.sv
// Bundle of the serial input strobe and parallel result outputs of the mod-5 receiver.
// The master side drives the serial bit stream; the slave side is the receiver.
interface serial_mod5_receiver_if #(
    parameter int DATA_W = 8,
    parameter int CHK_W  = 3
);
    logic              sin_valid;
    logic              sin_data;
    logic              sin_first;
    logic [DATA_W-1:0] data_out;
    logic [2:0]        res_out;
    logic [CHK_W-1:0]  chk_out;
    logic              out_valid;
    logic              mod_err;
    logic              frame_abort;
    logic              busy;
    logic [3:0]        state;

    modport master (
        output sin_valid, sin_data, sin_first,
        input  data_out, res_out, chk_out, out_valid, mod_err, frame_abort, busy, state
    );

    modport slave (
        input  sin_valid, sin_data, sin_first,
        output data_out, res_out, chk_out, out_valid, mod_err, frame_abort, busy, state
    );
endinterface

// File: rtl/serial_mod5_receiver.sv
// Deserializes an MSB-first word plus check field, tracks word mod 5 bit by bit and
// reports word, residue, received check and mismatch with a one-cycle valid pulse.
module serial_mod5_receiver #(
    parameter int DATA_W = 8,   // must be >= 2
    parameter int CHK_W  = 3    // must be >= 3
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_mod5_receiver_if.slave bus
);

    localparam int CNT_MAX = (DATA_W > CHK_W) ? DATA_W : CHK_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] DATA  = 4'd1;
    localparam logic [3:0] CHECK = 4'd2;
    localparam logic [3:0] DONE  = 4'd9;

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CHK_LAST  = CNT_W'(CHK_W - 1);

    logic [3:0]        state_q,       state_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [DATA_W-1:0] shift_q,       shift_d;
    logic [2:0]        res_q,         res_d;
    logic [CHK_W-1:0]  chk_q,         chk_d;
    logic [DATA_W-1:0] data_out_q,    data_out_d;
    logic [2:0]        res_out_q,     res_out_d;
    logic [CHK_W-1:0]  chk_out_q,     chk_out_d;
    logic              mod_err_q,     mod_err_d;
    logic              out_valid_q,   out_valid_d;
    logic              frame_abort_q, frame_abort_d;

    logic              start;
    logic              load;
    logic [DATA_W-1:0] shift_next;
    logic [CHK_W-1:0]  chk_next;

    // (2r + x) mod 5 with r in 0..4; 2r + x never exceeds 9, so one subtract suffices.
    function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic x);
        logic [3:0] t;
        t = {r, x};
        return (t >= 4'd5) ? 3'(t - 4'd5) : t[2:0];
    endfunction

    assign start      = bus.sin_valid & bus.sin_first;
    assign shift_next = {shift_q[DATA_W-2:0], bus.sin_data};
    assign chk_next   = {chk_q[CHK_W-2:0], bus.sin_data};

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        res_d         = res_q;
        chk_d         = chk_q;
        data_out_d    = data_out_q;
        res_out_d     = res_out_q;
        chk_out_d     = chk_out_q;
        mod_err_d     = mod_err_q;
        out_valid_d   = 1'b0;
        frame_abort_d = 1'b0;
        load          = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) load = 1'b1;
                else       state_d = IDLE;
            end
            DATA: begin
                if (start) begin
                    load          = 1'b1;
                    frame_abort_d = 1'b1;
                end else if (bus.sin_valid) begin
                    shift_d = shift_next;
                    res_d   = mod5_step(res_q, bus.sin_data);
                    if (cnt_q == DATA_LAST) begin
                        state_d = CHECK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (start) begin
                    load          = 1'b1;
                    frame_abort_d = 1'b1;
                end else if (bus.sin_valid) begin
                    chk_d = chk_next;
                    if (cnt_q == CHK_LAST) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        data_out_d  = shift_q;
                        res_out_d   = res_q;
                        chk_out_d   = chk_next;
                        mod_err_d   = (chk_next != CHK_W'(res_q));
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A frame start (fresh, back-to-back or restart) always takes the bit as data MSB.
        if (load) begin
            state_d = DATA;
            cnt_d   = CNT_W'(1);
            shift_d = DATA_W'(bus.sin_data);
            res_d   = {2'b00, bus.sin_data};
            chk_d   = '0;
        end
    end

    // NOTE: the shift and check registers are plain flops, so they take the async reset
    //       like the rest of the state; there is no RAM here that would forbid it.
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            res_q         <= '0;
            chk_q         <= '0;
            data_out_q    <= '0;
            res_out_q     <= '0;
            chk_out_q     <= '0;
            mod_err_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            res_q         <= res_d;
            chk_q         <= chk_d;
            data_out_q    <= data_out_d;
            res_out_q     <= res_out_d;
            chk_out_q     <= chk_out_d;
            mod_err_q     <= mod_err_d;
            out_valid_q   <= out_valid_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.res_out     = res_out_q;
    assign bus.chk_out     = chk_out_q;
    assign bus.mod_err     = mod_err_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.frame_abort = frame_abort_q;
    assign bus.busy        = (state_q == DATA) || (state_q == CHECK);
    assign bus.state       = state_q;

endmodule
